// File: rtl/intersection_pkg.sv
// Shared light encodings, controller state enum and head decode for intersection_ctrl.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package intersection_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [2:0] {
        MAIN_G,
        MAIN_Y,
        RED1,
        SIDE_G,
        SIDE_Y,
        RED2,
        FLASH
    } state_t;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
    } heads_t;

    // Timer reload value for a phase of t cycles; zero or negative durations act as one cycle.
    function automatic int dur_m1(input int t);
        return (t < 1) ? 0 : t - 1;
    endfunction

    function automatic heads_t heads_of(input state_t st, input logic lit);
        heads_t h;
        h.main = RED;
        h.side = RED;
        case (st)
            MAIN_G: h.main = GREEN;
            MAIN_Y: h.main = YELLOW;
            SIDE_G: h.side = GREEN;
            SIDE_Y: h.side = YELLOW;
            FLASH: begin
                h.main = lit ? YELLOW : DARK;
                h.side = lit ? RED : DARK;
            end
            default: ;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; expired is high while the count is zero.
// Latency: load takes effect on the next edge; expired is combinational from the count.
// Backpressure: none.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer with all-red clearance, side/ped demand and night flash.
// Latency: outputs registered, change on the same edge as the state.
// Backpressure: none; requests are sticky until served.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int T_MAIN_MIN = 20,
    parameter int T_SIDE     = 10,
    parameter int T_YEL      = 4,
    parameter int T_RED      = 2,
    parameter int T_FLASH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_btn,
    input  logic       flash_en,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk
);

    localparam logic [CNT_W-1:0] D_MAIN  = CNT_W'(dur_m1(T_MAIN_MIN));
    localparam logic [CNT_W-1:0] D_SIDE  = CNT_W'(dur_m1(T_SIDE));
    localparam logic [CNT_W-1:0] D_YEL   = CNT_W'(dur_m1(T_YEL));
    localparam logic [CNT_W-1:0] D_RED   = CNT_W'(dur_m1(T_RED));
    localparam logic [CNT_W-1:0] D_FLASH = CNT_W'(dur_m1(T_FLASH));

    state_t           state_q, state_d;
    logic             phase_exp, phase_load;
    logic [CNT_W-1:0] phase_val;
    logic             flash_exp, flash_load;
    logic             flash_lit_q, flash_lit_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             walk_lat, walk_lat_d;
    logic             entering_side, in_flash;
    heads_t           heads_d;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (D_RED)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val (phase_val),
        .expired  (phase_exp)
    );

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (D_FLASH)
    ) u_flash_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (flash_load),
        .load_val (D_FLASH),
        .expired  (flash_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A request seen this very cycle counts, so demand after min green leaves on the next edge.
            MAIN_G: if (phase_exp && (side_pend_q || ped_pend_q || side_req || ped_btn)) state_d = MAIN_Y;
            MAIN_Y: if (phase_exp) state_d = RED1;
            RED1:   if (phase_exp) state_d = SIDE_G;
            SIDE_G: if (phase_exp) state_d = SIDE_Y;
            SIDE_Y: if (phase_exp) state_d = RED2;
            RED2:   if (phase_exp) state_d = MAIN_G;
            FLASH:  state_d = RED2;
            default: state_d = RED2;
        endcase
        if (flash_en) begin
            state_d = FLASH;
        end
    end

    always_comb begin
        phase_val = '0;
        case (state_d)
            MAIN_G:         phase_val = D_MAIN;
            MAIN_Y, SIDE_Y: phase_val = D_YEL;
            RED1, RED2:     phase_val = D_RED;
            SIDE_G:         phase_val = D_SIDE;
            default:        phase_val = '0;
        endcase
    end

    assign phase_load    = (state_d != state_q);
    assign entering_side = (state_d == SIDE_G) && (state_q != SIDE_G);
    assign in_flash      = (state_q == FLASH) || (state_d == FLASH);

    // Blink timer free-reloads outside FLASH so the first lit half is always full length.
    assign flash_load  = (state_q != FLASH) || flash_exp;
    assign flash_lit_d = (state_q != FLASH) ? 1'b1 : (flash_exp ? ~flash_lit_q : flash_lit_q);

    always_comb begin
        side_pend_d = side_pend_q | side_req;
        ped_pend_d  = ped_pend_q | ped_btn;
        walk_lat_d  = (state_d == SIDE_G) ? walk_lat : 1'b0;
        if (in_flash) begin
            side_pend_d = 1'b0;
            ped_pend_d  = 1'b0;
            walk_lat_d  = 1'b0;
        end else if (entering_side) begin
            side_pend_d = side_req;
            ped_pend_d  = ped_btn;
            walk_lat_d  = ped_pend_q;
        end
    end

    assign heads_d = heads_of(state_d, flash_lit_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RED2;
            flash_lit_q <= 1'b1;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            walk_lat    <= 1'b0;
            main_light  <= RED;
            side_light  <= RED;
        end else begin
            state_q     <= state_d;
            flash_lit_q <= flash_lit_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            walk_lat    <= walk_lat_d;
            main_light  <= heads_d.main;
            side_light  <= heads_d.side;
        end
    end

    assign ped_walk = walk_lat;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scenario bench for intersection_ctrl: expected head/walk values per cycle are queued up front
// and a monitor pops one entry after every rising edge while the queue is non-empty.
module tb_intersection_ctrl;
    import intersection_pkg::*;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_btn  = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] main_light, side_light;
    logic       ped_walk;

    typedef struct {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        int         idx;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    errors   = 0;
    int    push_idx = 0;
    string scen     = "init";

    always #5 clk = ~clk;

    intersection_ctrl #(
        .CNT_W      (8),
        .T_MAIN_MIN (20),
        .T_SIDE     (10),
        .T_YEL      (4),
        .T_RED      (2),
        .T_FLASH    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .side_req   (side_req),
        .ped_btn    (ped_btn),
        .flash_en   (flash_en),
        .main_light (main_light),
        .side_light (side_light),
        .ped_walk   (ped_walk)
    );

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (main_light !== mon_e.m || side_light !== mon_e.s || ped_walk !== mon_e.w) begin
                errors++;
                $display("FAIL %s obs %0d: got main=%b side=%b walk=%b, expected main=%b side=%b walk=%b",
                         scen, mon_e.idx, main_light, side_light, ped_walk, mon_e.m, mon_e.s, mon_e.w);
            end
        end
    end

    task automatic push_n(input logic [2:0] m, input logic [2:0] s, input logic w, input int n);
        for (int i = 0; i < n; i++) begin
            push_idx++;
            sb.push_back('{m, s, w, push_idx});
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must fall to reset values before any clock edge.
    task automatic do_reset(input string name);
        #3;
        scen  = name;
        rst_n = 1'b0;
        side_req = 1'b0;
        ped_btn  = 1'b0;
        flash_en = 1'b0;
        #1;
        checks++;
        if (main_light !== RED || side_light !== RED || ped_walk !== 1'b0) begin
            errors++;
            $display("FAIL %s async_reset: got main=%b side=%b walk=%b, expected main=100 side=100 walk=0",
                     name, main_light, side_light, ped_walk);
        end
        sb.delete();
        push_idx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset_idle");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 100);
        run(101);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_side();
        do_reset("side_req");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 20);
        push_n(YELLOW, RED, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(RED, GREEN, 1'b0, 10);
        push_n(RED, YELLOW, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(GREEN, RED, 1'b0, 25);
        run(4);
        side_req = 1'b1;
        run(1);
        side_req = 1'b0;
        run(63);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL side_req drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_ped();
        do_reset("ped_btn");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 28);
        push_n(YELLOW, RED, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(RED, GREEN, 1'b1, 10);
        push_n(RED, YELLOW, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(GREEN, RED, 1'b0, 20);
        run(29);
        ped_btn = 1'b1;
        run(1);
        ped_btn = 1'b0;
        run(41);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL ped_btn drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset("back_to_back");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 20);
        push_n(YELLOW, RED, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(RED, GREEN, 1'b0, 10);
        push_n(RED, YELLOW, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(GREEN, RED, 1'b0, 20);
        push_n(YELLOW, RED, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(RED, GREEN, 1'b0, 10);
        run(4);
        side_req = 1'b1;
        run(33);
        side_req = 1'b0;
        run(42);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_flash();
        do_reset("flash");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 20);
        push_n(YELLOW, RED, 1'b0, 4);
        push_n(RED, RED, 1'b0, 2);
        push_n(RED, GREEN, 1'b0, 3);
        push_n(YELLOW, RED, 1'b0, 8);
        push_n(DARK, DARK, 1'b0, 8);
        push_n(YELLOW, RED, 1'b0, 8);
        push_n(DARK, DARK, 1'b0, 8);
        push_n(RED, RED, 1'b0, 2);
        push_n(GREEN, RED, 1'b0, 25);
        run(4);
        side_req = 1'b1;
        run(1);
        side_req = 1'b0;
        run(25);
        flash_en = 1'b1;
        run(19);
        ped_btn = 1'b1;
        run(1);
        ped_btn = 1'b0;
        run(12);
        flash_en = 1'b0;
        run(27);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL flash drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset("reset_mid_pre");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 20);
        push_n(YELLOW, RED, 1'b0, 2);
        run(4);
        side_req = 1'b1;
        run(1);
        side_req = 1'b0;
        run(18);
        do_reset("reset_mid_post");
        push_n(RED, RED, 1'b0, 1);
        push_n(GREEN, RED, 1'b0, 30);
        run(31);
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_side();
        test_ped();
        test_back_to_back();
        test_flash();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
